lfsr_noise_gen: RTL and testbench

LFSR_NOISE_GEN -- requirements
Module: lfsr_noise_gen

---
 rtl/lfsr_pkg.sv | 113 +++++++++++
 rtl/lfsr_step.sv | 21 ++
 rtl/lfsr_noise_gen.sv | 129 ++++++++++++
 tb/tb_lfsr_noise_gen.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions: channel-width helper, maximal-length Galois tap table,
// supported-width table and FSM state encoding.
package lfsr_pkg;

  localparam int unsigned LFSR_MAX_WIDTH = 128;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_STEP = 2'd1,
    ST_OUT  = 2'd2
  } lfsr_state_e;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r++;
    end
    return r;
  endfunction

  function automatic logic [LFSR_MAX_WIDTH-1:0] tbit(input int unsigned t);
    return LFSR_MAX_WIDTH'(1) << (t - 1);
  endfunction

  // Mask bit (t-1) is set for every polynomial tap t; right-shifting Galois form.
  function automatic logic [LFSR_MAX_WIDTH-1:0] tap(input int unsigned width);
    case (width)
      3:   return tbit(3)  | tbit(2);
      4:   return tbit(4)  | tbit(3);
      5:   return tbit(5)  | tbit(3);
      6:   return tbit(6)  | tbit(5);
      7:   return tbit(7)  | tbit(6);
      8:   return tbit(8)  | tbit(6)  | tbit(5)  | tbit(4);
      9:   return tbit(9)  | tbit(5);
      10:  return tbit(10) | tbit(7);
      11:  return tbit(11) | tbit(9);
      12:  return tbit(12) | tbit(6)  | tbit(4)  | tbit(1);
      13:  return tbit(13) | tbit(4)  | tbit(3)  | tbit(1);
      14:  return tbit(14) | tbit(5)  | tbit(3)  | tbit(1);
      15:  return tbit(15) | tbit(14);
      16:  return tbit(16) | tbit(15) | tbit(13) | tbit(4);
      17:  return tbit(17) | tbit(14);
      18:  return tbit(18) | tbit(11);
      19:  return tbit(19) | tbit(6)  | tbit(2)  | tbit(1);
      20:  return tbit(20) | tbit(17);
      21:  return tbit(21) | tbit(19);
      22:  return tbit(22) | tbit(21);
      23:  return tbit(23) | tbit(18);
      24:  return tbit(24) | tbit(23) | tbit(22) | tbit(17);
      25:  return tbit(25) | tbit(22);
      26:  return tbit(26) | tbit(6)  | tbit(2)  | tbit(1);
      27:  return tbit(27) | tbit(5)  | tbit(2)  | tbit(1);
      28:  return tbit(28) | tbit(25);
      29:  return tbit(29) | tbit(27);
      30:  return tbit(30) | tbit(6)  | tbit(4)  | tbit(1);
      31:  return tbit(31) | tbit(28);
      32:  return tbit(32) | tbit(22) | tbit(2)  | tbit(1);
      33:  return tbit(33) | tbit(20);
      34:  return tbit(34) | tbit(27) | tbit(2)  | tbit(1);
      35:  return tbit(35) | tbit(33);
      36:  return tbit(36) | tbit(25);
      37:  return tbit(37) | tbit(5)  | tbit(4)  | tbit(3) | tbit(2) | tbit(1);
      38:  return tbit(38) | tbit(6)  | tbit(5)  | tbit(1);
      39:  return tbit(39) | tbit(35);
      40:  return tbit(40) | tbit(38) | tbit(21) | tbit(19);
      41:  return tbit(41) | tbit(38);
      42:  return tbit(42) | tbit(41) | tbit(20) | tbit(19);
      43:  return tbit(43) | tbit(42) | tbit(38) | tbit(37);
      44:  return tbit(44) | tbit(43) | tbit(18) | tbit(17);
      45:  return tbit(45) | tbit(44) | tbit(42) | tbit(41);
      46:  return tbit(46) | tbit(45) | tbit(26) | tbit(25);
      47:  return tbit(47) | tbit(42);
      48:  return tbit(48) | tbit(47) | tbit(21) | tbit(20);
      49:  return tbit(49) | tbit(40);
      50:  return tbit(50) | tbit(49) | tbit(24) | tbit(23);
      51:  return tbit(51) | tbit(50) | tbit(36) | tbit(35);
      52:  return tbit(52) | tbit(49);
      53:  return tbit(53) | tbit(52) | tbit(38) | tbit(37);
      54:  return tbit(54) | tbit(53) | tbit(18) | tbit(17);
      55:  return tbit(55) | tbit(31);
      56:  return tbit(56) | tbit(55) | tbit(35) | tbit(34);
      57:  return tbit(57) | tbit(50);
      58:  return tbit(58) | tbit(39);
      59:  return tbit(59) | tbit(58) | tbit(38) | tbit(37);
      60:  return tbit(60) | tbit(59);
      61:  return tbit(61) | tbit(60) | tbit(46) | tbit(45);
      62:  return tbit(62) | tbit(61) | tbit(6)  | tbit(5);
      63:  return tbit(63) | tbit(62);
      64:  return tbit(64) | tbit(63) | tbit(61) | tbit(60);
      128: return tbit(128) | tbit(126) | tbit(101) | tbit(99);
      default: return '0;
    endcase
  endfunction

  function automatic logic [LFSR_MAX_WIDTH:0] build_supported();
    logic [LFSR_MAX_WIDTH:0] m;
    m = '0;
    for (int unsigned w = 3; w <= 64; w++) m[w] = 1'b1;
    m[LFSR_MAX_WIDTH] = 1'b1;
    return m;
  endfunction

  localparam logic [LFSR_MAX_WIDTH:0] LFSR_SUPPORTED_WIDTHS = build_supported();

  function automatic bit width_supported(input int unsigned w);
    return (w <= LFSR_MAX_WIDTH) && LFSR_SUPPORTED_WIDTHS[w];
  endfunction

endpackage

// File: rtl/lfsr_step.sv
// One combinational Galois LFSR step with lock-up prevention (zero -> MSB-only).
module lfsr_step
  import lfsr_pkg::*;
#(
  parameter int unsigned OUTPUT_WIDTH = 32
) (
  input  logic [OUTPUT_WIDTH-1:0] state_i,
  output logic [OUTPUT_WIDTH-1:0] state_o
);

  localparam logic [OUTPUT_WIDTH-1:0] TAP      = OUTPUT_WIDTH'(tap(OUTPUT_WIDTH));
  localparam logic [OUTPUT_WIDTH-1:0] MSB_ONLY = {1'b1, {(OUTPUT_WIDTH-1){1'b0}}};

  logic [OUTPUT_WIDTH-1:0] shifted;

  always_comb begin
    shifted = (state_i >> 1) ^ (state_i[0] ? TAP : '0);
    state_o = (shifted == '0) ? MSB_ONLY : shifted;
  end

endmodule

// File: rtl/lfsr_noise_gen.sv
// Multi-channel LFSR noise generator: per-channel state, request/step/output FSM
// with output backpressure and seed writes accepted in any state.
module lfsr_noise_gen
  import lfsr_pkg::*;
#(
  parameter int unsigned NR_CHANNELS  = 4,
  parameter int unsigned OUTPUT_WIDTH = 32,
  parameter int unsigned STEPS        = 1,
  parameter bit          SIGNED       = 1'b0,
  localparam int unsigned CHANNEL_WIDTH = (clog2(NR_CHANNELS) < 1) ? 1 : clog2(NR_CHANNELS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [CHANNEL_WIDTH-1:0] rndm_ch,
  input  logic                     rndm_req,
  output logic                     rndm_req_ready,
  input  logic [CHANNEL_WIDTH-1:0] rndm_init_ch,
  input  logic [OUTPUT_WIDTH-1:0]  rndm_seed,
  input  logic                     rndm_init,
  output logic [OUTPUT_WIDTH-1:0]  rndm_out,
  output logic [CHANNEL_WIDTH-1:0] rndm_out_ch,
  output logic                     rndm_out_valid,
  input  logic                     rndm_out_ready
);

  localparam int unsigned             DEPTH    = 1 << CHANNEL_WIDTH;
  localparam logic [OUTPUT_WIDTH-1:0] MSB_ONLY = {1'b1, {(OUTPUT_WIDTH-1){1'b0}}};
  localparam logic [7:0]              LAST_CNT = 8'(STEPS - 1);

  if (!width_supported(OUTPUT_WIDTH)) begin : g_bad_width
    $error("lfsr_noise_gen: unsupported OUTPUT_WIDTH %0d", OUTPUT_WIDTH);
  end
  if (STEPS < 1 || STEPS > OUTPUT_WIDTH) begin : g_bad_steps
    $error("lfsr_noise_gen: STEPS %0d out of range", STEPS);
  end
  if (NR_CHANNELS < 1 || NR_CHANNELS > 256) begin : g_bad_channels
    $error("lfsr_noise_gen: NR_CHANNELS %0d out of range", NR_CHANNELS);
  end

  lfsr_state_e state_q, state_d;

  logic [OUTPUT_WIDTH-1:0]  chan_q [DEPTH];
  logic [OUTPUT_WIDTH-1:0]  work_q;
  logic [CHANNEL_WIDTH-1:0] ch_q;
  logic [7:0]               step_cnt_q;
  logic [OUTPUT_WIDTH-1:0]  out_q;
  logic [CHANNEL_WIDTH-1:0] out_ch_q;

  logic [OUTPUT_WIDTH-1:0]  step_nxt;
  logic [OUTPUT_WIDTH-1:0]  out_map;
  logic                     req_ch_ok;
  logic                     init_ok;
  logic                     accept;
  logic                     last_step;

  lfsr_step #(
    .OUTPUT_WIDTH(OUTPUT_WIDTH)
  ) u_step (
    .state_i(work_q),
    .state_o(step_nxt)
  );

  always_comb begin
    req_ch_ok = int'(rndm_ch) < int'(NR_CHANNELS);
    init_ok   = rndm_init && (int'(rndm_init_ch) < int'(NR_CHANNELS));
    accept    = (state_q == ST_IDLE) && rndm_req && req_ch_ok;
    last_step = (state_q == ST_STEP) && (step_cnt_q == LAST_CNT);
    out_map   = (SIGNED && (step_nxt == MSB_ONLY)) ? '0 : step_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Out-of-range requests are consumed in IDLE without leaving it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept)         state_d = ST_STEP;
      ST_STEP: if (last_step)      state_d = ST_OUT;
      ST_OUT:  if (rndm_out_ready) state_d = ST_IDLE;
      default:                     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rndm_req_ready = (state_q == ST_IDLE);
    rndm_out_valid = (state_q == ST_OUT);
    rndm_out       = out_q;
    rndm_out_ch    = out_ch_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work_q     <= '0;
      ch_q       <= '0;
      step_cnt_q <= '0;
      out_q      <= '0;
      out_ch_q   <= '0;
    end else if (accept) begin
      work_q     <= chan_q[rndm_ch];
      ch_q       <= rndm_ch;
      step_cnt_q <= '0;
    end else if (state_q == ST_STEP) begin
      work_q     <= step_nxt;
      step_cnt_q <= step_cnt_q + 8'd1;
      if (last_step) begin
        out_q    <= out_map;
        out_ch_q <= ch_q;
      end
    end
  end

  // Seed takes priority per entry, so a write-back to another channel is never lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) chan_q[i] <= OUTPUT_WIDTH'(1);
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (init_ok && (rndm_init_ch == CHANNEL_WIDTH'(i)))
          chan_q[i] <= rndm_seed;
        else if (last_step && (ch_q == CHANNEL_WIDTH'(i)))
          chan_q[i] <= step_nxt;
      end
    end
  end

endmodule

// File: tb/tb_lfsr_noise_gen.sv
// Scoreboard bench for lfsr_noise_gen: three 8-bit instances (STEPS=1, STEPS=2, SIGNED=1),
// five channels each so that channel 5 is an out-of-range request.
module tb_lfsr_noise_gen;

  localparam int unsigned NDUT = 3;
  localparam int unsigned STEPS_T  [NDUT] = '{1, 2, 1};
  localparam bit          SIGNED_T [NDUT] = '{1'b0, 1'b0, 1'b1};

  logic       clk;
  logic       rst;
  logic [2:0] ch        [NDUT];
  logic       req       [NDUT];
  logic       req_ready [NDUT];
  logic [2:0] init_ch   [NDUT];
  logic [7:0] seed      [NDUT];
  logic       init      [NDUT];
  logic [7:0] out       [NDUT];
  logic [2:0] out_ch    [NDUT];
  logic       out_valid [NDUT];
  logic       out_ready [NDUT];

  int unsigned passed;
  int unsigned total;
  logic [12:0] sb[$];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    lfsr_noise_gen #(
      .NR_CHANNELS (5),
      .OUTPUT_WIDTH(8),
      .STEPS       (STEPS_T[g]),
      .SIGNED      (SIGNED_T[g])
    ) u_dut (
      .clk           (clk),
      .rst           (rst),
      .rndm_ch       (ch[g]),
      .rndm_req      (req[g]),
      .rndm_req_ready(req_ready[g]),
      .rndm_init_ch  (init_ch[g]),
      .rndm_seed     (seed[g]),
      .rndm_init     (init[g]),
      .rndm_out      (out[g]),
      .rndm_out_ch   (out_ch[g]),
      .rndm_out_valid(out_valid[g]),
      .rndm_out_ready(out_ready[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every output handshake pops one expected {dut, channel, value}.
  initial begin
    forever begin
      @(negedge clk);
      for (int d = 0; d < int'(NDUT); d++) begin
        if (!rst && out_valid[d] && out_ready[d]) begin
          if (sb.size() == 0) begin
            total++;
            $display("FAIL sb_unexpected: dut %0d got ch %0d value 0x%0h, none expected", d, out_ch[d], out[d]);
          end else begin
            logic [12:0] e;
            e = sb.pop_front();
            chk("sb_output", {19'd0, 2'(d), out_ch[d], out[d]}, {19'd0, e});
          end
        end
      end
    end
  end

  task automatic seed_ch(input int d, input logic [2:0] c, input logic [7:0] s);
    @(posedge clk); #1;
    init[d] = 1'b1; init_ch[d] = c; seed[d] = s;
    @(posedge clk); #1;
    init[d] = 1'b0;
  endtask

  task automatic wait_done(input int d);
    int n;
    n = 0;
    while (!out_valid[d] && n < 40) begin @(posedge clk); #1; n++; end
    while (out_valid[d] && n < 40) begin @(posedge clk); #1; n++; end
    if (n >= 40) begin
      total++;
      $display("FAIL timeout: dut %0d draw did not complete within 40 cycles", d);
    end
  endtask

  task automatic issue(input int d, input logic [2:0] c, input logic [7:0] e);
    sb.push_back({2'(d), c, e});
    ch[d] = c; req[d] = 1'b1;
    @(posedge clk); #1;
    req[d] = 1'b0;
  endtask

  task automatic draw(input int d, input logic [2:0] c, input logic [7:0] e);
    issue(d, c, e);
    wait_done(d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    passed = 0;
    total  = 0;
    rst    = 1'b1;
    for (int d = 0; d < int'(NDUT); d++) begin
      ch[d] = '0; req[d] = 1'b0; init_ch[d] = '0; seed[d] = '0; init[d] = 1'b0; out_ready[d] = 1'b1;
    end

    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid[0]), 32'd0);
    chk("rst_out", 32'(out[0]), 32'd0);
    chk("rst_out_ch", 32'(out_ch[0]), 32'd0);
    chk("rst_req_ready", 32'(req_ready[0]), 32'd1);

    // First request sits on the first clock after reset release; channel state is 1.
    @(negedge clk);
    rst = 1'b0;
    draw(0, 3'd2, 8'hB8);

    seed_ch(0, 3'd0, 8'h01);
    draw(0, 3'd0, 8'hB8);
    draw(0, 3'd0, 8'h5C);

    seed_ch(0, 3'd1, 8'h02);
    seed_ch(0, 3'd0, 8'h01);
    draw(0, 3'd0, 8'hB8);
    draw(0, 3'd1, 8'h01);
    draw(0, 3'd0, 8'h5C);
    draw(0, 3'd1, 8'hB8);
    draw(0, 3'd4, 8'hB8);

    // Backpressure: ch0 0x5C -> 0x2E held while ready is low.
    out_ready[0] = 1'b0;
    issue(0, 3'd0, 8'h2E);
    begin
      int n;
      n = 0;
      while (!out_valid[0] && n < 20) begin @(posedge clk); #1; n++; end
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_out", 32'(out[0]), 32'h2E);
      chk("bp_valid", 32'(out_valid[0]), 32'd1);
      chk("bp_req_ready", 32'(req_ready[0]), 32'd0);
    end
    @(posedge clk); #1;
    out_ready[0] = 1'b1;
    wait_done(0);

    // Out-of-range channel: consumed, no output, ready again next clock.
    ch[0] = 3'd5; req[0] = 1'b1;
    @(posedge clk); #1;
    req[0] = 1'b0;
    chk("inv_req_ready", 32'(req_ready[0]), 32'd1);
    chk("inv_valid", 32'(out_valid[0]), 32'd0);
    repeat (3) begin @(posedge clk); #1; end
    chk("inv_valid_later", 32'(out_valid[0]), 32'd0);
    draw(0, 3'd0, 8'h17);

    // Seed lands on the write-back edge of an in-flight ch0 draw.
    issue(0, 3'd0, 8'hB3);
    init[0] = 1'b1; init_ch[0] = 3'd0; seed[0] = 8'h33;
    @(posedge clk); #1;
    init[0] = 1'b0;
    wait_done(0);
    draw(0, 3'd0, 8'hA1);

    seed_ch(0, 3'd3, 8'h00);
    draw(0, 3'd3, 8'h80);
    draw(0, 3'd3, 8'h40);
    seed_ch(0, 3'd2, 8'h71);
    draw(0, 3'd2, 8'h80);

    seed_ch(2, 3'd0, 8'h71);
    draw(2, 3'd0, 8'h00);
    draw(2, 3'd0, 8'h40);
    seed_ch(2, 3'd1, 8'h01);
    draw(2, 3'd1, 8'hB8);

    // STEPS=2 latency, with an early seed that the write-back must overwrite.
    seed_ch(1, 3'd0, 8'h01);
    issue(1, 3'd0, 8'h5C);
    init[1] = 1'b1; init_ch[1] = 3'd0; seed[1] = 8'h77;
    @(posedge clk); #1;
    init[1] = 1'b0;
    chk("lat_valid_1clk", 32'(out_valid[1]), 32'd0);
    @(posedge clk); #1;
    chk("lat_valid_2clk", 32'(out_valid[1]), 32'd1);
    wait_done(1);
    draw(1, 3'd0, 8'h17);

    // Reset during STEP discards the draw and restores every channel to 1.
    ch[0] = 3'd0; req[0] = 1'b1;
    @(posedge clk); #1;
    req[0] = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("midrst_valid", 32'(out_valid[0]), 32'd0);
    chk("midrst_req_ready", 32'(req_ready[0]), 32'd1);
    chk("midrst_out", 32'(out[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    draw(0, 3'd0, 8'hB8);
    draw(0, 3'd3, 8'hB8);
    draw(1, 3'd0, 8'h5C);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
